seg_capture: RTL and testbench

// - Reverse path of the hex-to-7-segment display path: samples a multiplexed active-low 7-seg bus plus

---
 rtl/seg_capture_pkg.sv | 25 ++
 rtl/seg_pattern_match.sv | 38 +++
 rtl/seg_capture.sv | 110 +++++++++++
 tb/tb_seg_capture.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/seg_capture_pkg.sv
// Shared 7-segment glyph table (active-high, bit0=a .. bit6=g) used by both the
// display encoder and this capture path, so the two tables cannot drift apart.
package seg_capture_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_HEX_0 = 7'h3F;
  localparam seg_t SEG_HEX_1 = 7'h06;
  localparam seg_t SEG_HEX_2 = 7'h5B;
  localparam seg_t SEG_HEX_3 = 7'h4F;
  localparam seg_t SEG_HEX_4 = 7'h66;
  localparam seg_t SEG_HEX_5 = 7'h6D;
  localparam seg_t SEG_HEX_6 = 7'h7D;
  localparam seg_t SEG_HEX_7 = 7'h07;
  localparam seg_t SEG_HEX_8 = 7'h7F;
  localparam seg_t SEG_HEX_9 = 7'h6F;
  localparam seg_t SEG_HEX_A = 7'h77;
  localparam seg_t SEG_HEX_B = 7'h7C;
  localparam seg_t SEG_HEX_C = 7'h39;
  localparam seg_t SEG_HEX_D = 7'h5E;
  localparam seg_t SEG_HEX_E = 7'h79;
  localparam seg_t SEG_HEX_F = 7'h71;
  localparam seg_t SEG_BLANK = 7'h00;

endpackage

// File: rtl/seg_pattern_match.sv
// Combinational inverse of the hex display encoder: active-high segment pattern
// to nibble, with hit low for any pattern that is not one of the 16 glyphs.
module seg_pattern_match
  import seg_capture_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       hit
);

  always_comb begin
    nibble = 4'h0;
    hit    = 1'b1;
    case (pattern)
      SEG_HEX_0: nibble = 4'h0;
      SEG_HEX_1: nibble = 4'h1;
      SEG_HEX_2: nibble = 4'h2;
      SEG_HEX_3: nibble = 4'h3;
      SEG_HEX_4: nibble = 4'h4;
      SEG_HEX_5: nibble = 4'h5;
      SEG_HEX_6: nibble = 4'h6;
      SEG_HEX_7: nibble = 4'h7;
      SEG_HEX_8: nibble = 4'h8;
      SEG_HEX_9: nibble = 4'h9;
      SEG_HEX_A: nibble = 4'hA;
      SEG_HEX_B: nibble = 4'hB;
      SEG_HEX_C: nibble = 4'hC;
      SEG_HEX_D: nibble = 4'hD;
      SEG_HEX_E: nibble = 4'hE;
      SEG_HEX_F: nibble = 4'hF;
      default: begin
        nibble = 4'h0;
        hit    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seg_capture.sv
// Recovers the hex digits shown on a multiplexed active-low 7-seg bus and emits
// one frame (all digits) per valid pulse, flagging unrecognised glyphs.
module seg_capture
  import seg_capture_pkg::*;
#(
  parameter int NUM_DIGITS = 2,
  parameter int SETTLE     = 4
)(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic                    valid,
  output logic                    frame_err
);

  localparam int             CNT_W     = $clog2(SETTLE + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(SETTLE);
  localparam logic [CNT_W-1:0] SAMPLE_AT = CNT_W'(SETTLE - 2);

  logic [6:0]              seg_p0, seg_p1;
  logic [NUM_DIGITS-1:0]   sel_p0, sel_p1;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic [NUM_DIGITS-1:0]   lit, mask, mask_nxt, bad, bad_nxt;
  logic [4*NUM_DIGITS-1:0] shadow;
  logic                    onehot, changed, sample, frame_done;
  logic [3:0]              nib;
  logic                    hit;

  function automatic logic exactly_one(input logic [NUM_DIGITS-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < NUM_DIGITS; i++) n += int'(v[i]);
    return (n == 1);
  endfunction

  // Stage p0: input registers; p1 holds the previous cycle for change detection
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_p0 <= ~SEG_BLANK;
      sel_p0 <= '1;
      seg_p1 <= ~SEG_BLANK;
      sel_p1 <= '1;
    end else begin
      seg_p0 <= seg;
      sel_p0 <= dig_sel;
      seg_p1 <= seg_p0;
      sel_p1 <= sel_p0;
    end
  end

  seg_pattern_match u_match (
    .pattern (~seg_p0),
    .nibble  (nib),
    .hit     (hit)
  );

  assign lit        = ~sel_p0;
  assign onehot     = exactly_one(lit);
  assign changed    = (seg_p0 != seg_p1) || (sel_p0 != sel_p1);
  // Sampling on the SETTLE-2 -> SETTLE-1 step fires once; a saturated count never re-samples.
  assign sample     = onehot && !changed && (cnt == SAMPLE_AT);
  assign frame_done = &mask;

  always_comb begin
    cnt_nxt = cnt;
    if (!onehot || changed) begin
      cnt_nxt = '0;
    end else if (cnt != CNT_MAX) begin
      cnt_nxt = cnt + CNT_W'(1);
    end
  end

  // Frame completion clears first so a coincident sample opens the next frame.
  always_comb begin
    mask_nxt = frame_done ? '0 : mask;
    bad_nxt  = frame_done ? '0 : bad;
    if (sample) begin
      mask_nxt = mask_nxt | lit;
      bad_nxt  = (bad_nxt & ~lit) | (hit ? '0 : lit);
    end
  end

  // Stage p1: stability counter, shadow/mask/bad, frame output
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      mask      <= '0;
      bad       <= '0;
      shadow    <= '0;
      value     <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      cnt   <= cnt_nxt;
      mask  <= mask_nxt;
      bad   <= bad_nxt;
      valid <= frame_done;
      for (int d = 0; d < NUM_DIGITS; d++) begin
        if (sample && lit[d]) shadow[4*d +: 4] <= nib;
      end
      if (frame_done) begin
        value     <= shadow;
        frame_err <= |bad;
      end
    end
  end

endmodule

// File: tb/tb_seg_capture.sv
// Directed bench for seg_capture (NUM_DIGITS=2, SETTLE=4): table of full frames
// plus hand sequences for reset, glitch, blanking and overwrite corner cases.
module tb_seg_capture;

  logic       clk;
  logic       rst;
  logic [6:0] seg;
  logic [1:0] dig_sel;
  logic [7:0] value;
  logic       valid;
  logic       frame_err;

  int total;
  int passed;
  int pulses;

  // Active-low bus encodings of the glyphs used below
  localparam logic [6:0] L_0   = 7'b1000000;
  localparam logic [6:0] L_1   = 7'b1111001;
  localparam logic [6:0] L_2   = 7'b0100100;
  localparam logic [6:0] L_3   = 7'b0110000;
  localparam logic [6:0] L_5   = 7'b0010010;
  localparam logic [6:0] L_6   = 7'b0000010;
  localparam logic [6:0] L_7   = 7'b1111000;
  localparam logic [6:0] L_8   = 7'b0000000;
  localparam logic [6:0] L_A   = 7'b0001000;
  localparam logic [6:0] L_B   = 7'b0000011;
  localparam logic [6:0] L_C   = 7'b1000110;
  localparam logic [6:0] L_D   = 7'b0100001;
  localparam logic [6:0] L_F   = 7'b0001110;
  localparam logic [6:0] L_BAD = 7'b1111110;
  localparam logic [6:0] L_BLK = 7'b1111111;

  typedef struct {
    string      name;
    logic [6:0] s0;
    logic [6:0] s1;
    logic [7:0] ev;
    logic       ee;
  } frame_t;

  frame_t tbl [6];

  seg_capture #(.NUM_DIGITS(2), .SETTLE(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .seg       (seg),
    .dig_sel   (dig_sel),
    .value     (value),
    .valid     (valid),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Drive the bus for n cycles, counting cycles where valid is high.
  task automatic show(input logic [6:0] s, input logic [1:0] d, input int n);
    seg     = s;
    dig_sel = d;
    repeat (n) begin
      @(negedge clk);
      if (valid === 1'b1) pulses++;
    end
  endtask

  task automatic frame(input logic [6:0] s0, input logic [6:0] s1);
    pulses = 0;
    show(s0, 2'b10, 6);
    show(s1, 2'b01, 6);
    show(L_BLK, 2'b11, 4);
  endtask

  initial begin
    total  = 0;
    passed = 0;
    pulses = 0;
    tbl[0] = '{"norm_a5", L_5, L_A, 8'hA5, 1'b0};
    tbl[1] = '{"inv_a",   L_3, L_BAD, 8'h03, 1'b1};
    tbl[2] = '{"f0",      L_F, L_0, 8'h0F, 1'b0};
    tbl[3] = '{"blank_d", L_BLK, L_8, 8'h80, 1'b1};
    tbl[4] = '{"bd",      L_D, L_B, 8'hBD, 1'b0};
    tbl[5] = '{"c6",      L_6, L_C, 8'hC6, 1'b0};

    rst = 1'b1;
    seg = L_BLK;
    dig_sel = 2'b11;
    repeat (3) @(negedge clk);
    chk("rst_value", 32'(value), 32'h00);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_err",   32'(frame_err), 32'h0);
    rst = 1'b0;

    // Reset after digit 0 is captured discards the partial frame
    pulses = 0;
    show(L_5, 2'b10, 6);
    rst = 1'b1;
    show(L_BLK, 2'b11, 3);
    rst = 1'b0;
    chk("midrst_value", 32'(value), 32'h00);
    show(L_A, 2'b01, 6);
    show(L_BLK, 2'b11, 4);
    chk("midrst_pulses", 32'(pulses), 32'd0);
    pulses = 0;
    show(L_5, 2'b10, 6);
    show(L_BLK, 2'b11, 4);
    chk("postrst_pulses", 32'(pulses), 32'd1);
    chk("postrst_value",  32'(value), 32'hA5);
    chk("postrst_err",    32'(frame_err), 32'h0);

    for (int i = 0; i < 6; i++) begin
      frame(tbl[i].s0, tbl[i].s1);
      chk({tbl[i].name, "_pulses"}, 32'(pulses), 32'd1);
      chk({tbl[i].name, "_value"},  32'(value), 32'(tbl[i].ev));
      chk({tbl[i].name, "_err"},    32'(frame_err), 32'(tbl[i].ee));
    end

    // Glitch: digit 0 held only 3 cycles must not be sampled
    pulses = 0;
    show(L_2, 2'b10, 3);
    show(L_1, 2'b01, 6);
    show(L_BLK, 2'b11, 4);
    chk("glitch_pulses", 32'(pulses), 32'd0);
    chk("glitch_hold",   32'(value), 32'hC6);
    show(L_7, 2'b10, 6);
    show(L_BLK, 2'b11, 4);
    chk("glitch_done_pulses", 32'(pulses), 32'd1);
    chk("glitch_done_value",  32'(value), 32'h17);
    chk("glitch_done_err",    32'(frame_err), 32'h0);

    // Blanking and multi-select never sample
    pulses = 0;
    show(L_8, 2'b11, 20);
    show(L_8, 2'b00, 20);
    show(L_1, 2'b01, 6);
    show(L_BLK, 2'b11, 4);
    chk("blank_pulses", 32'(pulses), 32'd0);
    chk("blank_value",  32'(value), 32'h17);

    // Overwrite: digit 1 already captured above; finish that frame first
    show(L_0, 2'b10, 6);
    show(L_BLK, 2'b11, 4);
    chk("blank_done_value", 32'(value), 32'h10);

    pulses = 0;
    show(L_3, 2'b10, 6);
    show(L_7, 2'b10, 6);
    show(L_1, 2'b01, 6);
    show(L_BLK, 2'b11, 4);
    chk("ovw_pulses", 32'(pulses), 32'd1);
    chk("ovw_value",  32'(value), 32'h17);
    chk("ovw_err",    32'(frame_err), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
